// File: rtl/unet_host_sequencer.sv
// unet_host_sequencer: launches one unet_fsm_3_1 pass, streams weight/data ROM words
// to it, stores its results, and flags overrun / illegal-code / timeout errors.
module unet_host_sequencer #(
    parameter int WADDR_W   = 10,
    parameter int DADDR_W   = 12,
    parameter int RADDR_W   = 12,
    parameter int N_WEIGHTS = 9,
    parameter int N_DATA    = 1024,
    parameter int N_RESULTS = 1024,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               seq_busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [RADDR_W:0]   result_count,
    output logic               unet_enpulse,
    input  logic [2:0]         acc_ctrl,
    input  logic               acc_busy,
    output logic [31:0]        acc_data_in,
    input  logic [31:0]        acc_data_out,
    output logic               w_rd_en,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [31:0]        w_rdata,
    output logic               d_rd_en,
    output logic [DADDR_W-1:0] d_addr,
    input  logic [31:0]        d_rdata,
    output logic               r_wr_en,
    output logic [RADDR_W-1:0] r_addr,
    output logic [31:0]        r_wdata
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, KICK, WAIT_BUSY, RUN, FINISH, ERROR} state_t;

    state_t            state, state_nx;
    logic [WADDR_W:0]  w_cnt;
    logic [DADDR_W:0]  d_cnt;
    logic [RADDR_W:0]  r_cnt;
    logic [WD_W-1:0]   wd;
    logic [1:0]        sel;
    logic [1:0]        err_nx;
    logic              launch, xfer, wd_hit, counting;

    // wd_hit marks the last tolerated idle cycle, so ERROR lands on the edge ending it
    assign wd_hit   = wd == WD_W'(TIMEOUT - 1);
    assign launch   = (state == IDLE || state == ERROR) && start;
    assign counting = state == WAIT_BUSY || state == RUN;
    assign xfer     = w_rd_en || d_rd_en || r_wr_en;

    always_comb begin
        state_nx = state;
        err_nx   = err_code;
        w_rd_en  = 1'b0;
        d_rd_en  = 1'b0;
        r_wr_en  = 1'b0;
        case (state)
            IDLE:      state_nx = start ? KICK : IDLE;
            KICK:      state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (acc_busy) state_nx = RUN;
                else if (wd_hit) begin
                    state_nx = ERROR;
                    err_nx   = 2'd3;
                end
            end
            RUN: begin
                if (!acc_busy || acc_ctrl == 3'd4) state_nx = FINISH;
                else if (acc_ctrl == 3'd1) begin
                    if (w_cnt == (WADDR_W+1)'(N_WEIGHTS)) begin
                        state_nx = ERROR;
                        err_nx   = 2'd1;
                    end else w_rd_en = 1'b1;
                end else if (acc_ctrl == 3'd2) begin
                    if (d_cnt == (DADDR_W+1)'(N_DATA)) begin
                        state_nx = ERROR;
                        err_nx   = 2'd1;
                    end else d_rd_en = 1'b1;
                end else if (acc_ctrl == 3'd3) begin
                    if (r_cnt == (RADDR_W+1)'(N_RESULTS)) begin
                        state_nx = ERROR;
                        err_nx   = 2'd1;
                    end else r_wr_en = 1'b1;
                end else if (acc_ctrl > 3'd4) begin
                    state_nx = ERROR;
                    err_nx   = 2'd2;
                end else if (wd_hit) begin
                    state_nx = ERROR;
                    err_nx   = 2'd3;
                end
            end
            FINISH:    state_nx = IDLE;
            ERROR:     state_nx = start ? KICK : ERROR;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            err_code <= 2'd0;
            w_cnt    <= '0;
            d_cnt    <= '0;
            r_cnt    <= '0;
            wd       <= '0;
            sel      <= 2'b00;
        end else begin
            state    <= state_nx;
            err_code <= err_nx;
            sel      <= {d_rd_en, w_rd_en};
            // counters are cleared at launch so result_count survives FINISH
            if (launch) begin
                err_code <= 2'd0;
                w_cnt    <= '0;
                d_cnt    <= '0;
                r_cnt    <= '0;
                wd       <= '0;
            end else begin
                if (w_rd_en) w_cnt <= w_cnt + (WADDR_W+1)'(1);
                if (d_rd_en) d_cnt <= d_cnt + (DADDR_W+1)'(1);
                if (r_wr_en) r_cnt <= r_cnt + (RADDR_W+1)'(1);
                wd <= (xfer || !counting) ? '0 : wd + WD_W'(1);
            end
        end
    end

    assign seq_busy     = !(state == IDLE || state == ERROR);
    assign done         = state == FINISH;
    assign error        = state == ERROR;
    assign unet_enpulse = state == KICK;
    assign result_count = r_cnt;
    assign w_addr       = w_cnt[WADDR_W-1:0];
    assign d_addr       = d_cnt[DADDR_W-1:0];
    assign r_addr       = r_cnt[RADDR_W-1:0];
    assign r_wdata      = r_wr_en ? acc_data_out : 32'd0;
    assign acc_data_in  = sel[0] ? w_rdata : sel[1] ? d_rdata : 32'd0;
endmodule

// File: tb/tb_unet_host_sequencer.sv
// tb_unet_host_sequencer: randomized passes against a transfer-level model with ROM/RAM
// environment models; covers nominal pass, overrun, illegal code, timeout, mid-pass reset.
module tb_unet_host_sequencer;
    localparam int N_W = 9, N_D = 16, N_R = 16, TMO = 32;

    logic        clk = 1'b0, rst_n, start, acc_busy;
    logic        seq_busy, done, error, unet_enpulse;
    logic [1:0]  err_code;
    logic [12:0] result_count;
    logic [2:0]  acc_ctrl;
    logic [31:0] acc_data_in, acc_data_out, w_rdata, d_rdata, r_wdata;
    logic        w_rd_en, d_rd_en, r_wr_en;
    logic [9:0]  w_addr;
    logic [11:0] d_addr, r_addr;

    logic [31:0] wrom [16];
    logic [31:0] drom [16];
    int          m_w, m_d, m_r, errs = 0, checks = 0;
    logic [31:0] m_prev;

    unet_host_sequencer #(.N_WEIGHTS(N_W), .N_DATA(N_D), .N_RESULTS(N_R), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seq_busy(seq_busy), .done(done),
        .error(error), .err_code(err_code), .result_count(result_count),
        .unet_enpulse(unet_enpulse), .acc_ctrl(acc_ctrl), .acc_busy(acc_busy),
        .acc_data_in(acc_data_in), .acc_data_out(acc_data_out),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .d_rd_en(d_rd_en), .d_addr(d_addr), .d_rdata(d_rdata),
        .r_wr_en(r_wr_en), .r_addr(r_addr), .r_wdata(r_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= wrom[w_addr[3:0]];
        if (d_rd_en) d_rdata <= drom[d_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, seq_busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_code"}, err_code, 0);
        chk({tag, "_count"}, result_count, 0);
        chk({tag, "_pulse"}, unet_enpulse, 0);
        chk({tag, "_din"}, acc_data_in, 0);
        chk({tag, "_en"}, {w_rd_en, d_rd_en, r_wr_en}, 0);
        chk({tag, "_addr"}, {w_addr, d_addr, r_addr}, 0);
        chk({tag, "_wdata"}, r_wdata, 0);
    endtask

    task automatic launch();
        start = 1'b1; acc_busy = 1'b0; acc_ctrl = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("kick_pulse", unet_enpulse, 1);
        chk("kick_error", {error, err_code}, 0);
        chk("kick_count", result_count, 0);
        @(posedge clk); #1;
        repeat (1 + $urandom_range(3)) begin
            @(negedge clk);
            chk("wait_pulse", unet_enpulse, 0);
            chk("wait_busy", seq_busy, 1);
            @(posedge clk); #1;
        end
        acc_busy = 1'b1;
        @(posedge clk); #1;
        m_w = 0; m_d = 0; m_r = 0; m_prev = 0;
    endtask

    task automatic cyc(input logic [2:0] c);
        logic ew, ed, er;
        acc_ctrl = c; acc_data_out = $urandom;
        ew = c == 3'd1 && m_w < N_W;
        ed = c == 3'd2 && m_d < N_D;
        er = c == 3'd3 && m_r < N_R;
        @(negedge clk);
        chk("run_busy", seq_busy, 1);
        chk("run_pulse", unet_enpulse, 0);
        chk("acc_data_in", acc_data_in, m_prev);
        chk("w_rd_en", w_rd_en, ew);
        chk("d_rd_en", d_rd_en, ed);
        chk("r_wr_en", r_wr_en, er);
        if (ew) chk("w_addr", w_addr, m_w);
        if (ed) chk("d_addr", d_addr, m_d);
        if (er) begin
            chk("r_addr", r_addr, m_r);
            chk("r_wdata", r_wdata, acc_data_out);
        end
        m_prev = ew ? wrom[m_w] : ed ? drom[m_d] : 32'd0;
        m_w += int'(ew); m_d += int'(ed); m_r += int'(er);
        @(posedge clk); #1;
    endtask

    initial begin
        int q[$];
        int nd, nr;
        rst_n = 1'b0; start = 1'b0; acc_busy = 1'b0; acc_ctrl = 3'd0;
        acc_data_out = $urandom;
        for (int i = 0; i < 16; i++) begin
            wrom[i] = $urandom;
            drom[i] = $urandom;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // nominal pass with random interleave, idle gaps and a stray start in RUN
        launch();
        for (int i = 0; i < N_W; i++) q.push_back(1);
        nd = 0; nr = 0;
        while (nd < N_D || nr < N_R) begin
            if (nr >= N_R || (nd < N_D && $urandom_range(1) == 1)) begin
                q.push_back(2); nd++;
            end else begin
                q.push_back(3); nr++;
            end
            repeat ($urandom_range(2)) q.push_back(0);
        end
        q.push_back(4);
        foreach (q[i]) begin
            start = (i == 12);
            cyc(3'(q[i]));
        end
        start = 1'b0;
        @(negedge clk);
        chk("fin_done", done, 1);
        chk("fin_count", result_count, 16);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", seq_busy, 0);
        chk("idle_count", result_count, 16);
        @(posedge clk); #1;

        // weight overrun
        launch();
        repeat (N_W + 1) cyc(3'd1);
        @(negedge clk);
        chk("ovr_error", error, 1);
        chk("ovr_code", err_code, 1);
        chk("ovr_gate", {w_rd_en, seq_busy}, 0);
        @(posedge clk); #1;

        // illegal code, then relaunch from ERROR
        launch();
        cyc(3'd2);
        cyc(3'd6);
        acc_ctrl = 3'd2;
        @(negedge clk);
        chk("ill_error", error, 1);
        chk("ill_code", err_code, 2);
        chk("ill_gate", {unet_enpulse, w_rd_en, d_rd_en, r_wr_en}, 0);
        @(posedge clk); #1;

        // watchdog
        launch();
        cyc(3'd3);
        repeat (TMO) cyc(3'd0);
        @(negedge clk);
        chk("tmo_error", error, 1);
        chk("tmo_code", err_code, 3);
        @(posedge clk); #1;

        // asynchronous reset mid-pass
        launch();
        repeat (5) cyc(3'd2);
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        launch();
        cyc(3'd2);
        cyc(3'd4);
        @(negedge clk);
        chk("rst_done", done, 1);
        chk("rst_count", result_count, 0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/unet_host_sequencer.md
# unet_host_sequencer

Host-side controller that runs one complete inference pass on the `unet_fsm_3_1` accelerator. It launches the accelerator with `unet_enpulse`, then decodes the accelerator's `ctrl` code every cycle:
- serves weight and data words from two synchronous ROMs onto the accelerator input bus;
- writes each result word into a result RAM;
- flags protocol violations and stalls.

It sits between the system host (start/done) and the accelerator core.

## Interface
Parameters:
- `WADDR_W`, 10, weight ROM address width
- `DADDR_W`, 12, data ROM address width
- `RADDR_W`, 12, result RAM address width
- `N_WEIGHTS`, 9, weight words the accelerator may request per pass
- `N_DATA`, 1024, data words per pass
- `N_RESULTS`, 1024, maximum result words per pass
- `TIMEOUT`, 4096, watchdog limit in cycles

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled launch request.
- `seq_busy` out 1: high in every state except IDLE and ERROR.
- `done` out 1: one-cycle pulse at the end of a pass.
- `error` out 1: sticky error flag.
- `err_code` out 2: error cause. 1 = overrun, 2 = illegal ctrl, 3 = timeout.
- `result_count` out RADDR_W+1: number of results written in the current or last pass.
- `unet_enpulse` out 1: accelerator launch pulse.
- `acc_ctrl` in 3: accelerator ctrl code. 0 CALCULATING, 1 SEND_WEIGHTS, 2 SEND_DATA, 3 DATA_READY, 4 SAY_IDLE.
- `acc_busy` in 1: accelerator busy.
- `acc_data_in` out 32: word driven to the accelerator.
- `acc_data_out` in 32: accelerator result word.
- `w_rd_en` out 1, `w_addr` out WADDR_W, `w_rdata` in 32: weight ROM port, 1-cycle read latency.
- `d_rd_en` out 1, `d_addr` out DADDR_W, `d_rdata` in 32: data ROM port, 1-cycle read latency.
- `r_wr_en` out 1, `r_addr` out RADDR_W, `r_wdata` out 32: result RAM write port.

## Operation
States: IDLE, KICK, WAIT_BUSY, RUN, FINISH, ERROR.

- **IDLE**
  - `start` = 1 → KICK.
  - Clears the counters `w_cnt`, `d_cnt`, `r_cnt` and the watchdog.
  - Clears `error` and `err_code`.
- **KICK**
  - `unet_enpulse` = 1 for exactly this one cycle.
  - → WAIT_BUSY.
- **WAIT_BUSY**
  - `acc_busy` = 1 → RUN.
  - Watchdog reaches `TIMEOUT` → ERROR, code 3.
- **RUN** decodes `acc_ctrl` each cycle:
  - 1: assert `w_rd_en` with `w_addr` = `w_cnt`, then `w_cnt`++. A request with `w_cnt` == `N_WEIGHTS` → ERROR, code 1, and no read is issued.
  - 2: same as code 1, using `d_rd_en`/`d_addr`/`d_cnt` and `N_DATA`.
  - 3: assert `r_wr_en` with `r_addr` = `r_cnt` and `r_wdata` = `acc_data_out`, then `r_cnt`++. A write with `r_cnt` == `N_RESULTS` → ERROR, code 1.
  - 0: no transfer; the watchdog increments.
  - Any transfer (code 1, 2 or 3) clears the watchdog.
  - 4, or `acc_busy` = 0 → FINISH.
  - 5–7 → ERROR, code 2.
  - Watchdog == `TIMEOUT` → ERROR, code 3.
- **FINISH**
  - `done` = 1 for one cycle.
  - → IDLE.
- **ERROR**
  - `error` = 1; `unet_enpulse`, `w_rd_en`, `d_rd_en` and `r_wr_en` are all held at 0.
  - `start` = 1 → KICK, with counters and error cleared.
- **Input data path**
  - `acc_data_in` = `w_rdata` if the previous cycle issued a weight read.
  - `acc_data_in` = `d_rdata` if the previous cycle issued a data read.
  - Otherwise `acc_data_in` = 0.
  - The previous-cycle selection is a registered 2-bit select.
- **Result count:** `result_count` = `r_cnt`; it is held after FINISH until the next launch.
- **Start outside IDLE/ERROR:** `start` is ignored in every other state.

## Timing
- **Reset** (`rst_n` low, any cycle, including mid-pass):
  - state is IDLE and all counters are 0;
  - every output is 0, including `acc_data_in`.
- **Start latency:** `start` sampled at edge E0 → `unet_enpulse` high during cycle E0–E1 → WAIT_BUSY from E1.
- **Read handshake:**
  - A request decoded in cycle n issues the ROM read in cycle n.
  - The word is valid on `acc_data_in` in cycle n+1; the accelerator samples it at the end of n+1.
  - Back-to-back requests are serviced at 1 word/cycle.
- **Result write:** combinational in the same cycle as `acc_ctrl` == 3.
- **Watchdog:** a count of `TIMEOUT` consecutive non-transfer cycles triggers ERROR on the following edge.

## Test plan
- **Nominal pass**, accelerator model with `N_WEIGHTS` = 9, `N_DATA` = 16, 16 results.
  - Stimulus: model requests 9 weights, 16 data words, 16 DATA_READY, then SAY_IDLE.
  - Required: `w_addr` 0..8 and `d_addr` 0..15 in order; `acc_data_in` equals the ROM word one cycle after each request.
  - Required: results land at `r_addr` 0..15; one `done` pulse; `result_count` = 16.
- **Weight overrun:** 10th SEND_WEIGHTS request → `error` = 1 and `err_code` = 1 on the next edge; no 10th read issued.
- **Illegal code:** `acc_ctrl` = 6 in RUN → `err_code` = 2; all enables 0; `start` relaunches with a one-cycle `unet_enpulse`.
- **Timeout:** `TIMEOUT` = 32, `acc_ctrl` held at 0 with `acc_busy` = 1 → `err_code` = 3 exactly 32 cycles after the last transfer.
- **Reset mid-pass:** assert `rst_n` low after 5 data words → all outputs 0 immediately; a fresh `start` restarts with `d_addr` = 0.
- **Start ignored in RUN:** pulse `start` while in RUN → no second `unet_enpulse`; counters undisturbed.
